// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: producers write at clock rate, and
// the issue FSM hands bytes over one at a time, paced by tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          idle,
    output logic [7:0]    txdata,
    output logic          transmit,
    input  logic          tx_busy
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   level_q;
    logic          seen_busy;
    logic          wr_acc;
    logic          pop;

    // Flags come straight from the level register, so a pop in the same
    // cycle never frees a slot for that cycle's write.
    assign full   = (level_q == DEPTH_L);
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign wr_acc = wr_en && !full;
    assign idle   = empty && (state_q == IDLE) && !tx_busy;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (seen_busy && !tx_busy) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seen_busy <= 1'b0;
            transmit  <= 1'b0;
            txdata    <= 8'h00;
            wp        <= '0;
            rp        <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q  <= state_d;
            transmit <= pop;
            overflow <= wr_en && full;
            if (pop) begin
                txdata <= mem[rp];
                rp     <= rp + 1'b1;
            end
            if (wr_acc) begin
                wp <= wp + 1'b1;
            end
            // The transmitter may take a cycle to raise tx_busy after the
            // issue, so WAIT_DONE only trusts a low tx_busy once it was high.
            if (state_q == WAIT_DONE) begin
                if (seen_busy && !tx_busy) begin
                    seen_busy <= 1'b0;
                end else if (tx_busy) begin
                    seen_busy <= 1'b1;
                end
            end
            case ({wr_acc, pop})
                2'b10:   level_q <= level_q + ONE_L;
                2'b01:   level_q <= level_q - ONE_L;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART transmitter
// (CLKDIV=4) and a byte scoreboard checked on every transmit pulse.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int CLKDIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          idle;
    logic [7:0]    txdata;
    logic          transmit;
    logic          tx_busy;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int ovf_pulses = 0;
    logic tx_prev = 1'b0;
    logic [7:0] sb[$];

    logic       serial;
    logic [9:0] shreg;
    int         bit_cnt;
    int         div_cnt;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .empty(empty),
        .level(level),
        .overflow(overflow),
        .idle(idle),
        .txdata(txdata),
        .transmit(transmit),
        .tx_busy(tx_busy)
    );

    // Transmitter model: samples transmit when not busy, then shifts
    // start, 8 data bits LSB first and stop, CLKDIV cycles per bit.
    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            serial  <= 1'b1;
            shreg   <= '1;
            bit_cnt <= 0;
            div_cnt <= 0;
        end else if (!tx_busy) begin
            if (transmit) begin
                tx_busy <= 1'b1;
                shreg   <= {1'b1, txdata, 1'b0};
                serial  <= 1'b0;
                bit_cnt <= 0;
                div_cnt <= 0;
            end
        end else if (div_cnt == CLKDIV - 1) begin
            div_cnt <= 0;
            if (bit_cnt == 9) begin
                tx_busy <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 1;
                serial  <= shreg[bit_cnt + 1];
            end
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n;
        n = 0;
        while (!(idle === 1'b1 && sb.size() == 0) && n < max) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < max), 1);
    endtask

    // Scoreboard: every transmit pulse must carry the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && transmit === 1'b1) begin
            pulses++;
            check("tx_while_busy", 32'(tx_busy), 0);
            check("tx_width", 32'(tx_prev), 0);
            check("tx_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                check("tx_data", 32'(txdata), 32'(sb.pop_front()));
            end
        end
        if (!rst && overflow === 1'b1) begin
            ovf_pulses++;
        end
        tx_prev = transmit;
    end

    initial begin
        int base_p;
        int base_o;
        int n;
        logic [10:0] frame;

        // Reset then idle
        rst = 1'b1;
        tick(3);
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_transmit", 32'(transmit), 0);
        check("rst_txdata", 32'(txdata), 0);
        check("rst_idle", 32'(idle), 1);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_empty", 32'(empty), 1);
            check("idle_level", 32'(level), 0);
            check("idle_transmit", 32'(transmit), 0);
            check("idle_idle", 32'(idle), 1);
        end

        // Single byte
        wr_data = 8'hA5;
        wr_en = 1'b1;
        sb.push_back(8'hA5);
        tick(1);
        wr_en = 1'b0;
        check("single_level1", 32'(level), 1);
        check("single_no_tx_yet", 32'(transmit), 0);
        tick(1);
        check("single_transmit", 32'(transmit), 1);
        check("single_txdata", 32'(txdata), 32'hA5);
        check("single_level0", 32'(level), 0);
        tick(1);
        check("single_tx_drop", 32'(transmit), 0);
        tick(2);
        frame = {2'b11, 8'hA5, 1'b0};
        for (int k = 0; k < 11; k++) begin
            check($sformatf("serial_bit%0d", k), 32'(serial), 32'(frame[k]));
            if (k < 10) tick(CLKDIV);
        end
        wait_drain("single_idle", 100);
        check("single_idle_hi", 32'(idle), 1);

        // Burst ordering
        base_p = pulses;
        for (int i = 1; i <= 16; i++) begin
            wr_data = 8'(i);
            wr_en = 1'b1;
            sb.push_back(8'(i));
            tick(1);
        end
        wr_en = 1'b0;
        check("burst_level", 32'(level), 15);
        check("burst_not_full", 32'(full), 0);
        wait_drain("burst_drain", 2000);
        check("burst_pulses", 32'(pulses - base_p), 16);

        // Overflow while the transmitter is busy
        base_p = pulses;
        base_o = ovf_pulses;
        wr_data = 8'h20;
        wr_en = 1'b1;
        sb.push_back(8'h20);
        tick(1);
        wr_en = 1'b0;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h21 + i);
            wr_en = 1'b1;
            if (i < 16) sb.push_back(8'(8'h21 + i));
            tick(1);
            if (i == 14) begin
                check("ovf_level15", 32'(level), 15);
                check("ovf_not_full15", 32'(full), 0);
            end
            if (i == 15) begin
                check("ovf_full", 32'(full), 1);
                check("ovf_level16", 32'(level), 16);
                check("ovf_no_pulse_yet", 32'(overflow), 0);
            end
            if (i == 16) begin
                check("ovf_pulse", 32'(overflow), 1);
                check("ovf_level_hold", 32'(level), 16);
            end
        end
        wr_en = 1'b0;
        tick(1);
        check("ovf_pulse_end", 32'(overflow), 0);
        check("ovf_count", 32'(ovf_pulses - base_o), 1);
        wait_drain("ovf_drain", 3000);
        check("ovf_pulses", 32'(pulses - base_p), 17);

        // Simultaneous write and pop, 20 bytes from reset so wp wraps
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        wr_data = 8'h40;
        wr_en = 1'b1;
        sb.push_back(8'h40);
        tick(1);
        wr_en = 1'b0;
        tick(2);
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(8'h40 + i);
            wr_en = 1'b1;
            sb.push_back(8'(8'h40 + i));
            tick(1);
        end
        wr_en = 1'b0;
        check("sim_level3", 32'(level), 3);
        n = 0;
        while (tx_busy === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("sim_busy_fall", 32'(n < 100), 1);
        tick(1);
        wr_data = 8'h44;
        wr_en = 1'b1;
        sb.push_back(8'h44);
        tick(1);
        wr_en = 1'b0;
        check("sim_pop", 32'(transmit), 1);
        check("sim_level_same", 32'(level), 3);
        for (int i = 5; i < 15; i++) begin
            wr_data = 8'(8'h40 + i);
            wr_en = 1'b1;
            sb.push_back(8'(8'h40 + i));
            tick(1);
        end
        wr_en = 1'b0;
        check("sim_level13", 32'(level), 13);
        wait_drain("sim_drain1", 3000);
        for (int i = 15; i < 20; i++) begin
            wr_data = 8'(8'h40 + i);
            wr_en = 1'b1;
            sb.push_back(8'(8'h40 + i));
            tick(1);
        end
        wr_en = 1'b0;
        wait_drain("sim_drain2", 1000);
        check("sim_empty", 32'(empty), 1);

        // Reset mid-frame
        base_p = pulses;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h60 + i);
            wr_en = 1'b1;
            sb.push_back(8'(8'h60 + i));
            tick(1);
        end
        wr_en = 1'b0;
        n = 0;
        while (pulses - base_p < 2 && n < 500) begin
            tick(1);
            n++;
        end
        check("mid_second_issue", 32'(n < 500), 1);
        tick(10);
        rst = 1'b1;
        tick(1);
        check("mid_transmit", 32'(transmit), 0);
        check("mid_level", 32'(level), 0);
        check("mid_empty", 32'(empty), 1);
        rst = 1'b0;
        sb.delete();
        base_p = pulses;
        tick(300);
        check("mid_no_frames", 32'(pulses - base_p), 0);
        check("mid_idle", 32'(idle), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
